dual_issue_scheduler: RTL

//  In-order dual-issue front end for the two superscalar ALU/datapath lanes.

---
 rtl/dual_issue_scheduler.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/dual_issue_scheduler.sv
// In-order dual-issue front end: instruction queue, register decode, scoreboard and pair issue.
// Issue is combinational from the queue head; fetch_ready is registered and needs two free entries.
module dual_issue_scheduler #(
    parameter int QDEPTH   = 4,
    parameter int ALU_LAT  = 1,
    parameter int LOAD_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  fetch_valid,
    input  logic [31:0] fetch_instr0,
    input  logic [31:0] fetch_instr1,
    input  logic [31:0] fetch_pc0,
    input  logic [31:0] fetch_pc1,
    output logic        fetch_ready,
    input  logic        flush,
    output logic        issue0_valid,
    output logic [31:0] issue0_instr,
    output logic [31:0] issue0_pc,
    output logic        issue1_valid,
    output logic [31:0] issue1_instr,
    output logic [31:0] issue1_pc,
    output logic        stall
);
    localparam int PW = $clog2(QDEPTH);
    localparam int NW = PW + 1;
    localparam int CW = 4;
    localparam logic [CW-1:0] LOAD_SET = CW'(LOAD_LAT - 1);
    localparam logic [CW-1:0] ALU_SET  = CW'(ALU_LAT - 1);

    typedef struct packed {
        logic rs1;
        logic rs2;
        logic wr;
        logic load;
        logic mem;
        logic ctl;
        logic other;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] i);
        dec_t d;
        d = '0;
        case (i[6:0])
            7'b0110011: begin d.rs1 = 1'b1; d.rs2 = 1'b1; d.wr = 1'b1; end
            7'b0010011: begin d.rs1 = 1'b1; d.wr = 1'b1; end
            7'b0000011: begin d.rs1 = 1'b1; d.wr = 1'b1; d.load = 1'b1; d.mem = 1'b1; end
            7'b0100011: begin d.rs1 = 1'b1; d.rs2 = 1'b1; d.mem = 1'b1; end
            7'b1100011: begin d.rs1 = 1'b1; d.rs2 = 1'b1; d.ctl = 1'b1; end
            7'b1101111: begin d.wr = 1'b1; d.ctl = 1'b1; end
            7'b0110111: begin d.wr = 1'b1; end
            default:    begin d.rs1 = 1'b1; d.rs2 = 1'b1; d.wr = 1'b1; d.other = 1'b1; end
        endcase
        // Writes to x0 are never tracked, so they create no hazards either.
        d.wr = d.wr && (i[11:7] != 5'd0);
        return d;
    endfunction

    logic [31:0]   q_instr [QDEPTH];
    logic [31:0]   q_pc    [QDEPTH];
    logic [PW-1:0] head, tail, head1;
    logic [NW-1:0] count, count_nxt, enq_n, deq_n;
    logic [CW-1:0] cnt [32];
    logic [31:0]   h0, h1;
    dec_t          d0, d1;
    logic          rdy0, rdy1, raw1, waw1, iss0, iss1, enq, enq2;

    assign head1 = head + PW'(1);
    assign h0    = q_instr[head];
    assign h1    = q_instr[head1];
    assign d0    = decode(h0);
    assign d1    = decode(h1);

    assign rdy0 = (!d0.rs1 || cnt[h0[19:15]] == '0) && (!d0.rs2 || cnt[h0[24:20]] == '0)
               && (!d0.wr  || cnt[h0[11:7]]  == '0);
    assign rdy1 = (!d1.rs1 || cnt[h1[19:15]] == '0) && (!d1.rs2 || cnt[h1[24:20]] == '0)
               && (!d1.wr  || cnt[h1[11:7]]  == '0);
    assign raw1 = d0.wr && ((d1.rs1 && h1[19:15] == h0[11:7]) || (d1.rs2 && h1[24:20] == h0[11:7]));
    assign waw1 = d0.wr && d1.wr && (h1[11:7] == h0[11:7]);

    assign iss0 = (count != '0) && !flush && rdy0;
    assign iss1 = iss0 && (count >= NW'(2)) && !d0.ctl && !d0.other && !d1.other
               && !(d0.mem && d1.mem) && !raw1 && !waw1 && rdy1;

    assign issue0_valid = iss0;
    assign issue1_valid = iss1;
    assign issue0_instr = iss0 ? h0 : '0;
    assign issue1_instr = iss1 ? h1 : '0;
    assign issue0_pc    = iss0 ? q_pc[head]  : '0;
    assign issue1_pc    = iss1 ? q_pc[head1] : '0;
    assign stall        = (count != '0) && !iss0;

    assign enq       = fetch_ready && fetch_valid[0] && !flush;
    assign enq2      = enq && fetch_valid[1];
    assign enq_n     = enq2 ? NW'(2) : (enq ? NW'(1) : '0);
    assign deq_n     = iss1 ? NW'(2) : (iss0 ? NW'(1) : '0);
    assign count_nxt = count + enq_n - deq_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            fetch_ready <= 1'b1;
        end else if (flush) begin
            head        <= tail;
            count       <= '0;
            fetch_ready <= 1'b1;
        end else begin
            head        <= head + PW'(deq_n);
            tail        <= tail + PW'(enq_n);
            count       <= count_nxt;
            fetch_ready <= (count_nxt <= NW'(QDEPTH - 2));
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_instr[tail] <= fetch_instr0;
            q_pc[tail]    <= fetch_pc0;
        end
        if (enq2) begin
            q_instr[tail + PW'(1)] <= fetch_instr1;
            q_pc[tail + PW'(1)]    <= fetch_pc1;
        end
    end

    // Issue loads the counter; otherwise pending counts drain by one per edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) cnt[r] <= '0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (iss0 && d0.wr && h0[11:7] == 5'(r))
                    cnt[r] <= d0.load ? LOAD_SET : ALU_SET;
                else if (iss1 && d1.wr && h1[11:7] == 5'(r))
                    cnt[r] <= d1.load ? LOAD_SET : ALU_SET;
                else if (cnt[r] != '0)
                    cnt[r] <= cnt[r] - CW'(1);
            end
        end
    end
endmodule
